// File: rtl/aes_cipher_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : aes_cipher_ctrl
// Description : AES block-cipher sequencer. It handles key-expansion handshake,
//               round/column scheduling and ownership of the shared S-box.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_cipher_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       init,
    input  logic       next,
    input  logic       keylen,
    input  logic       key_ready,
    output logic       key_init,
    output logic [3:0] round,
    output logic [1:0] word_idx,
    output logic       sbox_sel,
    output logic [1:0] round_type,
    output logic       update,
    output logic       ready,
    output logic       result_valid,
    output logic       busy
);

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_KEY_START = 3'd1;
    localparam logic [2:0] c_ST_KEY_WAIT  = 3'd2;
    localparam logic [2:0] c_ST_READY     = 3'd3;
    localparam logic [2:0] c_ST_RND_INIT  = 3'd4;
    localparam logic [2:0] c_ST_RND_SUB   = 3'd5;
    localparam logic [2:0] c_ST_RND_UPD   = 3'd6;
    localparam logic [2:0] c_ST_DONE      = 3'd7;

    localparam logic [3:0] c_NR_128 = 4'd10;
    localparam logic [3:0] c_NR_256 = 4'd14;

    localparam logic [1:0] c_RT_NONE  = 2'd0;
    localparam logic [1:0] c_RT_INIT  = 2'd1;
    localparam logic [1:0] c_RT_MAIN  = 2'd2;
    localparam logic [1:0] c_RT_FINAL = 2'd3;

    logic [2:0] r_state;
    logic [3:0] r_round_ctr;
    logic [1:0] r_word_ctr;
    logic [3:0] r_nr;
    logic       r_seen_low;

    logic [2:0] w_state_nxt;
    logic [3:0] w_round_ctr_nxt;
    logic [1:0] w_word_ctr_nxt;
    logic [3:0] w_nr_nxt;
    logic       w_seen_low_nxt;
    logic       w_final_round;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_round_ctr <= 4'd0;
            r_word_ctr  <= 2'd0;
            r_nr        <= 4'd0;
            r_seen_low  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_round_ctr <= w_round_ctr_nxt;
            r_word_ctr  <= w_word_ctr_nxt;
            r_nr        <= w_nr_nxt;
            r_seen_low  <= w_seen_low_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_round_ctr_nxt = r_round_ctr;
        w_word_ctr_nxt  = r_word_ctr;
        w_nr_nxt        = r_nr;
        w_seen_low_nxt  = r_seen_low;
        case (r_state)
            c_ST_IDLE: begin
                if (init) begin
                    w_state_nxt = c_ST_KEY_START;
                    w_nr_nxt    = keylen ? c_NR_256 : c_NR_128;
                end
            end
            c_ST_KEY_START: begin
                w_seen_low_nxt = 1'b0;
                w_state_nxt    = c_ST_KEY_WAIT;
            end
            // A ready left high from the previous key must drop before it counts.
            c_ST_KEY_WAIT: begin
                if (!key_ready) begin
                    w_seen_low_nxt = 1'b1;
                end else if (r_seen_low) begin
                    w_state_nxt = c_ST_READY;
                end
            end
            c_ST_READY: begin
                if (init) begin
                    w_state_nxt = c_ST_KEY_START;
                    w_nr_nxt    = keylen ? c_NR_256 : c_NR_128;
                end else if (next) begin
                    w_state_nxt = c_ST_RND_INIT;
                end
            end
            c_ST_RND_INIT: begin
                w_round_ctr_nxt = 4'd1;
                w_word_ctr_nxt  = 2'd0;
                w_state_nxt     = c_ST_RND_SUB;
            end
            c_ST_RND_SUB: begin
                w_word_ctr_nxt = r_word_ctr + 2'd1;
                if (r_word_ctr == 2'd3) begin
                    w_state_nxt = c_ST_RND_UPD;
                end
            end
            c_ST_RND_UPD: begin
                if (r_round_ctr < r_nr) begin
                    w_round_ctr_nxt = r_round_ctr + 4'd1;
                    w_word_ctr_nxt  = 2'd0;
                    w_state_nxt     = c_ST_RND_SUB;
                end else begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                w_state_nxt = c_ST_READY;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    assign w_final_round = (r_round_ctr == r_nr);

    // Outputs depend on registered state only.
    always_comb begin
        key_init     = 1'b0;
        round        = 4'd0;
        word_idx     = 2'd0;
        sbox_sel     = 1'b0;
        round_type   = c_RT_NONE;
        update       = 1'b0;
        ready        = 1'b0;
        result_valid = 1'b0;
        busy         = 1'b1;
        case (r_state)
            c_ST_IDLE: begin
                busy = 1'b0;
            end
            c_ST_KEY_START: begin
                key_init = 1'b1;
            end
            c_ST_READY: begin
                ready = 1'b1;
                busy  = 1'b0;
            end
            c_ST_RND_INIT: begin
                round_type = c_RT_INIT;
                update     = 1'b1;
            end
            c_ST_RND_SUB: begin
                round      = r_round_ctr;
                word_idx   = r_word_ctr;
                sbox_sel   = 1'b1;
                round_type = w_final_round ? c_RT_FINAL : c_RT_MAIN;
            end
            c_ST_RND_UPD: begin
                round      = r_round_ctr;
                round_type = w_final_round ? c_RT_FINAL : c_RT_MAIN;
                update     = 1'b1;
            end
            c_ST_DONE: begin
                result_valid = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire
